// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//
// Purpose:
//   Shared definitions for the memory arbiter: FSM state encoding, bus owner
//   encoding, datapath widths and a small helper that names "the other
//   requester".
//
// Contents:
//   state_t     : IDLE / ACCESS / DONE arbiter states
//   owner_t     : OWN_CPU / OWN_DMA bus owner
//   DATA_W      : width of addresses and data words
//   CNT_W       : width of the wait-cycle counter (WAIT legal range 0..15)
//   other_owner : returns the requester that is not the argument
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // Used by the round-robin build to hand priority to whoever was not just
    // granted the bus.
    function automatic owner_t other_owner(input owner_t owner);
        return (owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//
// Purpose:
//   Purely combinational owner selection for the memory arbiter. When only
//   one requester is active it wins; when both are active the one named by
//   'prio' wins.
//
// Ports:
//   cpu_req  in  1  CPU request
//   dma_req  in  1  DMA request
//   prio     in  1  owner that wins a simultaneous request
//   grant    out 1  at least one request is active
//   owner    out 1  selected owner (meaningful only while grant=1)
// ---------------------------------------------------------------------------
module arb_pick
    import mips_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dma_req,
    input  owner_t prio,
    output logic   grant,
    output owner_t owner
);

    // A lone requester always wins; a tie is broken by the priority input.
    // With no request the owner output defaults to CPU and is ignored.
    always_comb begin
        grant = cpu_req | dma_req;
        owner = OWN_CPU;
        if (cpu_req && dma_req) begin
            owner = prio;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one memory port between a CPU and a DMA/loader. One access at a
//   time runs through IDLE -> ACCESS -> DONE. The owner's address, data and
//   write select are latched on entry to ACCESS, so requester inputs may move
//   while an access is in flight. ACCESS lasts WAIT+1 cycles; the single
//   write strobe and the read-data capture both happen in its last cycle.
//   DONE pulses the owner's ready for one cycle with the captured read data.
//
// Configuration:
//   MEM_ARB_RR_EN defined   : round-robin between CPU and DMA on ties, the
//                             requester not served last wins.
//   MEM_ARB_RR_EN undefined : fixed priority, CPU wins ties, no pointer flop.
//
// Parameters:
//   WAIT : memory wait cycles per access (0..15)
//
// Ports:
//   clk        in  1   system clock, rising edge
//   reset      in  1   synchronous active-high reset
//   cpu_req    in  1   CPU request          cpu_we  in 1  CPU write select
//   cpu_adr    in  32  CPU address          cpu_wd  in 32 CPU write data
//   cpu_rd     out 32  CPU read data (valid with cpu_ready, else 0)
//   cpu_ready  out 1   one-cycle CPU completion pulse
//   dma_req    in  1   DMA request          dma_we  in 1  DMA write select
//   dma_adr    in  32  DMA address          dma_wd  in 32 DMA write data
//   dma_rd     out 32  DMA read data (valid with dma_ready, else 0)
//   dma_ready  out 1   one-cycle DMA completion pulse
//   mem_we     out 1   shared memory write strobe
//   mem_adr    out 32  shared memory address
//   mem_wd     out 32  shared memory write data
//   mem_rd     in  32  shared memory read data
//   busy       out 1   arbiter not in IDLE
// ---------------------------------------------------------------------------
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_ready,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_adr,
    input  logic [DATA_W-1:0] dma_wd,
    output logic [DATA_W-1:0] dma_rd,
    output logic              dma_ready,

    output logic              mem_we,
    output logic [DATA_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,

    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [DATA_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              pick_grant;
    owner_t            pick_owner;
    owner_t            prio;

`ifdef MEM_ARB_RR_EN
    // Priority pointer: the owner that wins the next tie. Starts at CPU.
    owner_t            rr_q, rr_d;

    assign prio = rr_q;
`else
    assign prio = OWN_CPU;
`endif

    arb_pick u_arb_pick (
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .prio    (prio),
        .grant   (pick_grant),
        .owner   (pick_owner)
    );

    // State and datapath registers. Reset aborts any access in flight: the
    // FSM returns to IDLE so neither a ready pulse nor a write strobe can
    // appear in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_CPU;
            adr_q   <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            adr_q   <= adr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer register, kept separate so the fixed-priority
    // build carries no pointer flop at all.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= OWN_CPU;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Next-state logic. IDLE grabs a snapshot of the winning requester so
    // later input changes cannot disturb the access. ACCESS counts the wait
    // cycles down and captures memory read data when the count hits zero.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        adr_d   = adr_q;
        wd_d    = wd_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
        rr_d    = rr_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_grant) begin
                    owner_d = pick_owner;
                    if (pick_owner == OWN_DMA) begin
                        adr_d = dma_adr;
                        wd_d  = dma_wd;
                        we_d  = dma_we;
                    end else begin
                        adr_d = cpu_adr;
                        wd_d  = cpu_wd;
                        we_d  = cpu_we;
                    end
                    cnt_d   = WAIT_CNT;
                    state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
                    rr_d    = other_owner(pick_owner);
`endif
                end
            end

            ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_rd;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. The memory bus carries the latched request for the
    // whole access and is parked at zero in IDLE. The write strobe is
    // limited to the final ACCESS cycle so each access writes exactly once.
    // Read data is only presented to the owner, and only while its ready is
    // high; the other requester always sees zero.
    always_comb begin
        busy      = (state_q != IDLE);
        mem_adr   = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        dma_ready = 1'b0;
        cpu_rd    = '0;
        dma_rd    = '0;

        if (state_q != IDLE) begin
            mem_adr = adr_q;
            mem_wd  = wd_q;
        end

        if (state_q == ACCESS && cnt_q == '0) begin
            mem_we = we_q;
        end

        if (state_q == DONE) begin
            if (owner_q == OWN_DMA) begin
                dma_ready = 1'b1;
                dma_rd    = rdata_q;
            end else begin
                cpu_ready = 1'b1;
                cpu_rd    = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. The main instance (WAIT=1) talks to a
// small behavioural memory; a second instance (WAIT=0) checks short-latency
// timing. Expected ready pulses and write strobes are queued when stimulus is
// issued and checked by independent monitor processes. Build with
// MEM_ARB_RR_EN defined to expect round-robin ordering on simultaneous
// requests.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam int WAIT_MAIN = 1;

    typedef struct {
        bit          is_dma;
        logic [31:0] rd;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wd;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_mem;

    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_adr, cpu_wd, dma_adr, dma_wd;
    logic [31:0] cpu_rd, dma_rd;
    logic        cpu_ready, dma_ready;
    logic        mem_we;
    logic [31:0] mem_adr, mem_wd, mem_rd;
    logic        busy;

    logic        w0_cpu_req;
    logic [31:0] w0_cpu_adr;
    logic [31:0] w0_cpu_rd, w0_dma_rd;
    logic        w0_cpu_ready, w0_dma_ready;
    logic        w0_mem_we;
    logic [31:0] w0_mem_adr, w0_mem_wd;
    logic        w0_busy;
    logic        zero_bit;
    logic [31:0] zero_word;
    logic [31:0] w0_mem_rd;

    logic [31:0] mem [0:255];

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.WAIT(WAIT_MAIN)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_ready (cpu_ready),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_adr   (dma_adr),
        .dma_wd    (dma_wd),
        .dma_rd    (dma_rd),
        .dma_ready (dma_ready),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .busy      (busy)
    );

    mem_arbiter #(.WAIT(0)) u_dut_w0 (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (w0_cpu_req),
        .cpu_we    (zero_bit),
        .cpu_adr   (w0_cpu_adr),
        .cpu_wd    (zero_word),
        .cpu_rd    (w0_cpu_rd),
        .cpu_ready (w0_cpu_ready),
        .dma_req   (zero_bit),
        .dma_we    (zero_bit),
        .dma_adr   (zero_word),
        .dma_wd    (zero_word),
        .dma_rd    (w0_dma_rd),
        .dma_ready (w0_dma_ready),
        .mem_we    (w0_mem_we),
        .mem_adr   (w0_mem_adr),
        .mem_wd    (w0_mem_wd),
        .mem_rd    (w0_mem_rd),
        .busy      (w0_busy)
    );

    assign zero_bit  = 1'b0;
    assign zero_word = 32'h0;
    assign w0_mem_rd = 32'h0BAD_F00D;

    // Behavioural word memory: combinational read, write on the strobe.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[16] <= 32'h1234_ABCD;
            mem[17] <= 32'h5555_5555;
        end else if (mem_we) begin
            mem[mem_adr[9:2]] <= mem_wd;
        end
    end

    assign mem_rd = mem[mem_adr[9:2]];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready monitor: every completion pulse must match the next queued
    // response in owner, data and cycle.
    always @(negedge clk) begin
        if (cpu_ready || dma_ready) begin
            check_output("one_ready_at_a_time", {31'b0, cpu_ready & dma_ready}, 32'h0);
            if (rsp_q.size() == 0) begin
                check_output("unexpected_ready", {30'b0, dma_ready, cpu_ready}, 32'h0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check_output("ready_owner", {31'b0, dma_ready}, {31'b0, e.is_dma});
                check_output("ready_cycle", cyc, e.cyc);
                if (e.is_dma) begin
                    check_output("dma_rd", dma_rd, e.rd);
                    check_output("cpu_rd_nonowner", cpu_rd, 32'h0);
                end else begin
                    check_output("cpu_rd", cpu_rd, e.rd);
                    check_output("dma_rd_nonowner", dma_rd, 32'h0);
                end
            end
        end
    end

    // Write monitor: every strobe must match the next queued write.
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                check_output("unexpected_mem_we", {31'b0, mem_we}, 32'h0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check_output("mem_we_adr", mem_adr, w.adr);
                check_output("mem_we_wd", mem_wd, w.wd);
                check_output("mem_we_cycle", cyc, w.cyc);
            end
        end
    end

    task automatic wait_ready(input bit is_dma);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if ((is_dma && dma_ready) || (!is_dma && cpu_ready)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_output("ready_timeout", 32'h0, 32'h1);
    endtask

    // Issue one access from a single requester, queue its expected results
    // and hold the request until its ready pulse.
    task automatic apply_stimulus(input bit is_dma, input bit we, input logic [31:0] adr,
                                  input logic [31:0] wd, input logic [31:0] exp_rd);
        rsp_t e;
        wr_t  w;
        @(posedge clk);
        #1;
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_adr = adr; dma_wd = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wd = wd;
        end
        e.is_dma = is_dma;
        e.rd     = exp_rd;
        e.cyc    = cyc + WAIT_MAIN + 2;
        rsp_q.push_back(e);
        if (we) begin
            w.adr = adr;
            w.wd  = wd;
            w.cyc = cyc + WAIT_MAIN + 1;
            wr_q.push_back(w);
        end
        wait_ready(is_dma);
        if (is_dma) dma_req = 1'b0;
        else        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        int n;
        int busy_cnt;
        int ready_cnt;
        int ready_cyc;
        logic [31:0] ready_rd;
        rsp_t e;

        reset      = 1'b1;
        init_mem   = 1'b1;
        cpu_req    = 1'b0; cpu_we = 1'b0; cpu_adr = 32'h0; cpu_wd = 32'h0;
        dma_req    = 1'b0; dma_we = 1'b0; dma_adr = 32'h0; dma_wd = 32'h0;
        w0_cpu_req = 1'b0; w0_cpu_adr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;

        // Reset state, still inside reset.
        @(negedge clk);
        check_output("reset_busy", {31'b0, busy}, 32'h0);
        check_output("reset_cpu_ready", {31'b0, cpu_ready}, 32'h0);
        check_output("reset_dma_ready", {31'b0, dma_ready}, 32'h0);
        check_output("reset_mem_we", {31'b0, mem_we}, 32'h0);
        check_output("reset_mem_adr", mem_adr, 32'h0);
        check_output("reset_mem_wd", mem_wd, 32'h0);
        check_output("reset_cpu_rd", cpu_rd, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // CPU read of 0x40.
        apply_stimulus(1'b0, 1'b0, 32'h40, 32'h0, 32'h1234_ABCD);

        // CPU moves its address mid-access; the bus must keep 0x40.
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h40;
        e.is_dma = 1'b0; e.rd = 32'h1234_ABCD; e.cyc = cyc + 3;
        rsp_q.push_back(e);
        @(posedge clk);
        #1;
        cpu_adr = 32'h44;
        @(negedge clk);
        check_output("mid_access_adr_first", mem_adr, 32'h40);
        @(negedge clk);
        check_output("mid_access_adr_last", mem_adr, 32'h40);
        wait_ready(1'b0);
        cpu_req = 1'b0;
        cpu_adr = 32'h40;

        // DMA write of 0xDEADBEEF to 0x80; old contents were zero.
        apply_stimulus(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 32'h0);

        // Both requesters held high for four accesses.
        @(posedge clk);
        #1;
        k = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h40;
        dma_req = 1'b1; dma_we = 1'b0; dma_adr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            e.is_dma = RR && (i % 2 == 1);
            e.rd     = e.is_dma ? 32'hDEAD_BEEF : 32'h1234_ABCD;
            e.cyc    = k + 3 + 4 * i;
            rsp_q.push_back(e);
        end
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (cpu_ready || dma_ready) n++;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check_output("both_req_count", n, 32'd4);

        // CPU write aborted by reset while in ACCESS.
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h20; cpu_wd = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("abort_busy", {31'b0, busy}, 32'h0);
        check_output("abort_cpu_ready", {31'b0, cpu_ready}, 32'h0);
        check_output("abort_mem_we", {31'b0, mem_we}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // The aborted write must not have reached memory.
        apply_stimulus(1'b0, 1'b0, 32'h20, 32'h0, 32'h0);
        // Earlier DMA write is visible to the CPU.
        apply_stimulus(1'b0, 1'b0, 32'h80, 32'h0, 32'hDEAD_BEEF);

        // WAIT=0 instance: ready two cycles after request, busy two cycles.
        @(posedge clk);
        #1;
        k = cyc;
        w0_cpu_req = 1'b1;
        w0_cpu_adr = 32'h40;
        busy_cnt  = 0;
        ready_cnt = 0;
        ready_cyc = -1;
        ready_rd  = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (w0_busy) busy_cnt++;
            if (w0_cpu_ready) begin
                ready_cnt++;
                ready_cyc  = cyc;
                ready_rd   = w0_cpu_rd;
                w0_cpu_req = 1'b0;
            end
        end
        w0_cpu_req = 1'b0;
        check_output("w0_ready_count", ready_cnt, 32'd1);
        check_output("w0_ready_cycle", ready_cyc, k + 2);
        check_output("w0_cpu_rd", ready_rd, 32'h0BAD_F00D);
        check_output("w0_busy_cycles", busy_cnt, 32'd2);

        repeat (4) @(negedge clk);
        check_output("rsp_queue_empty", rsp_q.size(), 32'd0);
        check_output("wr_queue_empty", wr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
